cam_match_enumerator: RTL and testbench

Downstream stage of the CAM array. Accepts one decoded (multi-hot) match vector per search. Emits the binary address of every matching row, one per beat, lowest index first. Uses a valid/ready handshake so a slow consumer (e.g. a row-read or replacement unit) can apply backpressure. Reports the match count and, optionally, a miss beat when no row matches.

---
 rtl/cam_match_enumerator_if.sv | 28 ++
 rtl/cam_match_enumerator.sv | 138 +++++++++++++
 tb/tb_cam_match_enumerator.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_match_enumerator_if.sv
// Match-vector input and address-beat output bundle for the CAM match enumerator.
// The slave modport is the enumerator's view; master is the producer/consumer side.
interface cam_match_enumerator_if #(
  parameter int CAM_DEPTH  = 8,
  parameter int ADDR_WIDTH = 3
) ();

  logic [CAM_DEPTH-1:0]  match_vector;
  logic                  match_valid;
  logic                  match_ready;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic                  out_miss;
  logic [ADDR_WIDTH:0]   match_count;

  modport master (
    output match_vector, match_valid, out_ready,
    input  match_ready, out_addr, out_valid, out_last, out_miss, match_count
  );

  modport slave (
    input  match_vector, match_valid, out_ready,
    output match_ready, out_addr, out_valid, out_last, out_miss, match_count
  );

endinterface

// File: rtl/cam_match_enumerator.sv
// Enumerates set bits of a CAM match vector as ascending addresses, 1-cycle capture latency, held under out_ready backpressure.
// Define CAM_ENUM_MISS_REPORT_EN to emit a single miss beat for an all-zero vector.
module cam_match_enumerator #(
  parameter int CAM_DEPTH  = 8,
  parameter int ADDR_WIDTH = 3
) (
  input logic                   clk,
  input logic                   rst,
  cam_match_enumerator_if.slave bus
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CAM_DEPTH-1:0] ONE = CAM_DEPTH'(1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  logic [0:0]            state;
  logic [CAM_DEPTH-1:0]  pending;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  valid_q;
  logic                  last_q;
  logic [CNT_W-1:0]      count_q;

  logic [CAM_DEPTH-1:0]  cap_rest;
  logic [ADDR_WIDTH-1:0] cap_idx;
  logic [CNT_W-1:0]      cap_cnt;
  logic [CAM_DEPTH-1:0]  pend_rest;
  logic [ADDR_WIDTH-1:0] pend_idx;
  logic                  handshake;

  function automatic logic [ADDR_WIDTH-1:0] lowest_index(input logic [CAM_DEPTH-1:0] v);
    logic [ADDR_WIDTH-1:0] idx;
    idx = '0;
    // Scan downward so the last hit written is the lowest set bit.
    for (int i = CAM_DEPTH - 1; i >= 0; i--) begin
      if (v[i]) idx = ADDR_WIDTH'(i);
    end
    return idx;
  endfunction

  function automatic logic [CAM_DEPTH-1:0] clear_lowest(input logic [CAM_DEPTH-1:0] v);
    return v & (v - ONE);
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [CAM_DEPTH-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < CAM_DEPTH; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  always_comb begin
    cap_rest  = clear_lowest(bus.match_vector);
    cap_idx   = lowest_index(bus.match_vector);
    cap_cnt   = popcount(bus.match_vector);
    pend_rest = clear_lowest(pending);
    pend_idx  = lowest_index(pending);
    handshake = valid_q & bus.out_ready;
  end

`ifdef CAM_ENUM_MISS_REPORT_EN
  logic miss_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      miss_q <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.match_valid) miss_q <= ~|bus.match_vector;
    end else if (handshake && ~|pending) begin
      miss_q <= 1'b0;
    end
  end

  assign bus.out_miss = miss_q;
`else
  assign bus.out_miss = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      pending <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      count_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.match_valid) begin
            if (|bus.match_vector) begin
              pending <= cap_rest;
              addr_q  <= cap_idx;
              valid_q <= 1'b1;
              last_q  <= ~|cap_rest;
              count_q <= cap_cnt;
              state   <= EMIT;
            end else begin
              count_q <= '0;
`ifdef CAM_ENUM_MISS_REPORT_EN
              pending <= '0;
              addr_q  <= '0;
              valid_q <= 1'b1;
              last_q  <= 1'b1;
              state   <= EMIT;
`endif
            end
          end
        end
        EMIT: begin
          // Without a handshake every output register simply holds.
          if (handshake) begin
            if (|pending) begin
              addr_q  <= pend_idx;
              pending <= pend_rest;
              last_q  <= ~|pend_rest;
            end else begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.match_ready = (state == IDLE);
  assign bus.out_addr    = addr_q;
  assign bus.out_valid   = valid_q;
  assign bus.out_last    = last_q;
  assign bus.match_count = count_q;

endmodule

// File: tb/tb_cam_match_enumerator.sv
// Randomized bench for cam_match_enumerator against a per-bit enumeration reference model.
`timescale 1ns/1ps
module tb_cam_match_enumerator;

  localparam int D  = 8;
  localparam int AW = 3;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          last;
    logic          miss;
    logic [AW:0]   cnt;
  } beat_t;

  typedef struct packed {
    logic  valid;
    logic  rdy;
    logic  mready;
    beat_t b;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  obs_t  trace[$];
  beat_t got[$];
  beat_t exp_q[$];
  bit    timed_out;

  cam_match_enumerator_if #(.CAM_DEPTH(D), .ADDR_WIDTH(AW)) bus ();

  cam_match_enumerator #(.CAM_DEPTH(D), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: every set bit in ascending order, last on the highest one.
  function automatic void build_expected(input logic [D-1:0] v);
    int    hi;
    beat_t b;
    exp_q.delete();
    hi = -1;
    for (int i = 0; i < D; i++) if (v[i]) hi = i;
    for (int i = 0; i < D; i++) begin
      if (v[i]) begin
        b.addr = AW'(i);
        b.last = (i == hi);
        b.miss = 1'b0;
        b.cnt  = (AW+1)'($countones(v));
        exp_q.push_back(b);
      end
    end
`ifdef CAM_ENUM_MISS_REPORT_EN
    if (v == '0) begin
      b = '0;
      b.last = 1'b1;
      b.miss = 1'b1;
      exp_q.push_back(b);
    end
`endif
  endfunction

  function automatic obs_t sample(input logic r);
    obs_t o;
    o.valid  = bus.out_valid;
    o.rdy    = r;
    o.mready = bus.match_ready;
    o.b.addr = bus.out_addr;
    o.b.last = bus.out_last;
    o.b.miss = bus.out_miss;
    o.b.cnt  = bus.match_count;
    return o;
  endfunction

  // mode 0: always ready; 1: stall stall_len cycles on beat stall_beat; 2: random ready.
  task automatic run_search(input logic [D-1:0] v, input int mode, input int stall_beat,
                            input int stall_len, input bit noise);
    int   beat_idx;
    int   held;
    obs_t o;
    beat_idx = 0;
    held = 0;
    trace.delete();
    got.delete();
    timed_out = 1'b0;
    bus.match_vector = v;
    bus.match_valid  = 1'b1;
    @(negedge clk);
    bus.match_valid = 1'b0;
    for (int cyc = 0; ; cyc++) begin
      logic r;
      r = 1'b1;
      if (cyc >= 200) begin
        timed_out = 1'b1;
        break;
      end
      if (bus.out_valid) begin
        case (mode)
          1:       r = !(beat_idx == stall_beat && held < stall_len);
          2:       r = ($urandom_range(0, 3) != 0);
          default: r = 1'b1;
        endcase
        if (!r && beat_idx == stall_beat) held++;
      end
      o = sample(r);
      trace.push_back(o);
      bus.out_ready = r;
      if (o.valid && r) begin
        got.push_back(o.b);
        beat_idx++;
      end
      if (!o.valid) break;
      if (noise) begin
        bus.match_valid  = 1'($urandom_range(0, 1));
        bus.match_vector = D'($urandom);
      end
      @(negedge clk);
    end
    bus.match_valid = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o;
    rst = 1'b0;
    bus.match_vector = 8'hFF;
    bus.match_valid  = 1'b1;
    bus.out_ready    = 1'b1;
    repeat (2) @(negedge clk);
    o = sample(1'b1);
    checks++;
    if ({o.valid, o.mready, o.b} !== {1'b0, 1'b1, 9'h000}) begin
      failures++;
      $display("FAIL reset_state got valid=%b mready=%b beat=%h exp valid=0 mready=1 beat=000",
               o.valid, o.mready, o.b);
    end
    bus.match_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    build_expected(8'b1010_0100);
    run_search(8'b1010_0100, 0, 0, 0, 1'b0);
    checks++;
    if (timed_out !== 1'b0) begin failures++; $display("FAIL basic_timeout got=%b exp=0", timed_out); end
    checks++;
    if (got.size() != exp_q.size()) begin
      failures++;
      $display("FAIL basic_beat_count got=%0d exp=%0d", got.size(), exp_q.size());
    end else begin
      for (int i = 0; i < got.size(); i++) begin
        checks++;
        if (got[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL basic_beat%0d got=%h exp=%h", i, got[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (trace.size() != 4) begin
      failures++;
      $display("FAIL basic_cycles got=%0d exp=4", trace.size());
    end else begin
      checks++;
      if ({trace[0].valid, trace[0].mready, trace[2].mready, trace[3].valid, trace[3].mready, trace[3].b.cnt}
          !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3}) begin
        failures++;
        $display("FAIL basic_ready_timing got=%b%b%b%b%b cnt=%0d exp=10001 cnt=3", trace[0].valid,
                 trace[0].mready, trace[2].mready, trace[3].valid, trace[3].mready, trace[3].b.cnt);
      end
    end
  endtask

  task automatic test_backpressure();
    build_expected(8'b1010_0100);
    run_search(8'b1010_0100, 1, 1, 3, 1'b0);
    checks++;
    if (got.size() != exp_q.size()) begin
      failures++;
      $display("FAIL bp_beat_count got=%0d exp=%0d", got.size(), exp_q.size());
    end else begin
      for (int i = 0; i < got.size(); i++) begin
        checks++;
        if (got[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL bp_beat%0d got=%h exp=%h", i, got[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (trace.size() != 7) begin
      failures++;
      $display("FAIL bp_cycles got=%0d exp=7", trace.size());
    end
    for (int i = 0; i + 1 < trace.size(); i++) begin
      if (trace[i].valid && !trace[i].rdy) begin
        checks++;
        if ({trace[i+1].valid, trace[i+1].b} !== {1'b1, trace[i].b}) begin
          failures++;
          $display("FAIL bp_hold%0d got=%b/%h exp=1/%h", i, trace[i+1].valid, trace[i+1].b, trace[i].b);
        end
      end
    end
  endtask

  task automatic test_all_ones();
    build_expected(8'hFF);
    run_search(8'hFF, 0, 0, 0, 1'b1);
    checks++;
    if (got.size() != exp_q.size()) begin
      failures++;
      $display("FAIL ones_beat_count got=%0d exp=%0d", got.size(), exp_q.size());
    end else begin
      for (int i = 0; i < got.size(); i++) begin
        checks++;
        if (got[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL ones_beat%0d got=%h exp=%h", i, got[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (trace.size() != 9) begin
      failures++;
      $display("FAIL ones_cycles got=%0d exp=9", trace.size());
    end
  endtask

  task automatic test_zero();
    build_expected(8'h00);
    run_search(8'h00, 0, 0, 0, 1'b0);
    checks++;
    if (got.size() != exp_q.size()) begin
      failures++;
      $display("FAIL zero_beat_count got=%0d exp=%0d", got.size(), exp_q.size());
    end else begin
      for (int i = 0; i < got.size(); i++) begin
        checks++;
        if (got[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL zero_beat%0d got=%h exp=%h", i, got[i], exp_q[i]);
        end
      end
    end
    checks++;
    if ({trace[trace.size()-1].valid, trace[trace.size()-1].mready, trace[trace.size()-1].b.cnt}
        !== {1'b0, 1'b1, 4'd0}) begin
      failures++;
      $display("FAIL zero_idle got valid=%b mready=%b cnt=%0d exp valid=0 mready=1 cnt=0",
               trace[trace.size()-1].valid, trace[trace.size()-1].mready, trace[trace.size()-1].b.cnt);
    end
  endtask

  task automatic test_reset_mid_emit();
    obs_t o;
    bit   found;
    found = 1'b0;
    bus.out_ready    = 1'b1;
    bus.match_vector = 8'b1010_0100;
    bus.match_valid  = 1'b1;
    @(negedge clk);
    bus.match_valid = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (bus.out_valid && bus.out_addr == 3'd5) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (found !== 1'b1) begin failures++; $display("FAIL rst_mid_find_addr5 got=0 exp=1"); end
    rst = 1'b0;
    @(negedge clk);
    o = sample(1'b1);
    checks++;
    if ({o.valid, o.mready, o.b} !== {1'b0, 1'b1, 9'h000}) begin
      failures++;
      $display("FAIL rst_mid_state got valid=%b mready=%b beat=%h exp valid=0 mready=1 beat=000",
               o.valid, o.mready, o.b);
    end
    rst = 1'b1;
    build_expected(8'b0000_0001);
    run_search(8'b0000_0001, 0, 0, 0, 1'b0);
    checks++;
    if (got.size() != 1) begin
      failures++;
      $display("FAIL rst_mid_followup_count got=%0d exp=1", got.size());
    end else begin
      checks++;
      if (got[0] !== exp_q[0]) begin
        failures++;
        $display("FAIL rst_mid_followup_beat got=%h exp=%h", got[0], exp_q[0]);
      end
    end
  endtask

  task automatic test_random();
    logic [D-1:0] v;
    for (int n = 0; n < 40; n++) begin
      v = ($urandom_range(0, 7) == 0) ? '0 : D'($urandom);
      build_expected(v);
      run_search(v, 2, 0, 0, 1'($urandom_range(0, 1)));
      checks++;
      if (timed_out !== 1'b0 || got.size() != exp_q.size()) begin
        failures++;
        $display("FAIL rand%0d_count vec=%h got=%0d timeout=%b exp=%0d", n, v, got.size(), timed_out,
                 exp_q.size());
        continue;
      end
      for (int i = 0; i < got.size(); i++) begin
        checks++;
        if (got[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL rand%0d_beat%0d vec=%h got=%h exp=%h", n, i, v, got[i], exp_q[i]);
        end
      end
      for (int i = 0; i + 1 < trace.size(); i++) begin
        if (trace[i].valid && !trace[i].rdy) begin
          checks++;
          if ({trace[i+1].valid, trace[i+1].b} !== {1'b1, trace[i].b}) begin
            failures++;
            $display("FAIL rand%0d_hold%0d got=%b/%h exp=1/%h", n, i, trace[i+1].valid, trace[i+1].b,
                     trace[i].b);
          end
        end
      end
    end
  endtask

  initial begin
    rst              = 1'b0;
    bus.match_vector = '0;
    bus.match_valid  = 1'b0;
    bus.out_ready    = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_all_ones();
    test_zero();
    test_reset_mid_emit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
